// File: rtl/decompose_l3.sv
// Level-3 wavelet analysis stage: four a2 samples per beat in, two a3 and two d3
// coefficients out through an 8-tap low/high-pass filter bank with decimation by 2.
module decompose_l3 #(
  parameter int INTERNAL_WIDTH = 48,
  parameter int COEF_WIDTH     = 25,
  parameter int COEF_FRAC      = 23,
  parameter logic signed [COEF_WIDTH-1:0] DEC_L0 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_L1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_L2 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_L3 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_L4 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_L5 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_L6 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_L7 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_H0 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_H1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_H2 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_H3 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_H4 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_H5 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_H6 = '0,
  parameter logic signed [COEF_WIDTH-1:0] DEC_H7 = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             din_valid,
  input  logic signed [INTERNAL_WIDTH-1:0] a2_0,
  input  logic signed [INTERNAL_WIDTH-1:0] a2_1,
  input  logic signed [INTERNAL_WIDTH-1:0] a2_2,
  input  logic signed [INTERNAL_WIDTH-1:0] a2_3,
  output logic                             dout_valid,
  output logic signed [INTERNAL_WIDTH-1:0] a3_0,
  output logic signed [INTERNAL_WIDTH-1:0] a3_1,
  output logic signed [INTERNAL_WIDTH-1:0] d3_0,
  output logic signed [INTERNAL_WIDTH-1:0] d3_1
);

  localparam int PW = INTERNAL_WIDTH + COEF_WIDTH;
  localparam int SW = PW + 3;
  localparam logic signed [COEF_WIDTH-1:0] C_TAP [2][8] = '{
    '{DEC_L0, DEC_L1, DEC_L2, DEC_L3, DEC_L4, DEC_L5, DEC_L6, DEC_L7},
    '{DEC_H0, DEC_H1, DEC_H2, DEC_H3, DEC_H4, DEC_H5, DEC_H6, DEC_H7}
  };

  logic signed [INTERNAL_WIDTH-1:0] r_hist [6];
  logic [1:0]                       r_warm;
  logic                             w_valid_s0;
  logic signed [INTERNAL_WIDTH-1:0] w_win [10];
  logic signed [INTERNAL_WIDTH-1:0] w_tap [4][8];
  logic signed [PW-1:0]             r_prod [4][8];
  logic signed [SW-1:0]             w_sum [4];
  logic signed [SW-1:0]             r_sum [4];
  logic                             r_valid_s1;
  logic                             r_valid_s2;
  logic                             r_dout_valid;
  logic signed [INTERNAL_WIDTH-1:0] r_out [4];

  // Window w_win[k] = x[4j-6+k]; group g: bit0 selects phase p, bit1 selects high-pass.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      w_win[k] = r_hist[k];
    end
    w_win[6] = a2_0;
    w_win[7] = a2_1;
    w_win[8] = a2_2;
    w_win[9] = a2_3;
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 8; n++) begin
        w_tap[g][n] = w_win[(((g % 2) == 1) ? 9 : 7) - n];
      end
    end
    w_valid_s0 = din_valid & ~clr & (r_warm == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < 6; k++) r_hist[k] <= '0;
      r_warm <= 2'd0;
    end else if (din_valid) begin
      for (int k = 0; k < 6; k++) r_hist[k] <= w_win[k + 4];
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_valid_s1   <= 1'b0;
      r_valid_s2   <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_valid_s1   <= w_valid_s0;
      r_valid_s2   <= r_valid_s1;
      r_dout_valid <= r_valid_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < 4; g++)
        for (int n = 0; n < 8; n++) r_prod[g][n] <= '0;
    end else if (w_valid_s0) begin
      for (int g = 0; g < 4; g++)
        for (int n = 0; n < 8; n++)
          r_prod[g][n] <= PW'(w_tap[g][n]) * PW'(C_TAP[g / 2][n]);
    end
  end

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      w_sum[g] = '0;
      for (int n = 0; n < 8; n++) begin
        w_sum[g] = w_sum[g] + SW'(r_prod[g][n]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < 4; g++) r_sum[g] <= '0;
    end else if (r_valid_s1) begin
      for (int g = 0; g < 4; g++) r_sum[g] <= w_sum[g];
    end
  end

  // Arithmetic shift floors toward -inf; the width cast wraps on overflow. clr freezes the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < 4; g++) r_out[g] <= '0;
    end else if (r_valid_s2 && !clr) begin
      for (int g = 0; g < 4; g++) r_out[g] <= INTERNAL_WIDTH'(r_sum[g] >>> COEF_FRAC);
    end
  end

  assign dout_valid = r_dout_valid;
  assign a3_0       = r_out[0];
  assign a3_1       = r_out[1];
  assign d3_0       = r_out[2];
  assign d3_1       = r_out[3];

endmodule

// File: doc/decompose_l3.md
Name: decompose_L3

Overview:
- Third-level wavelet analysis stage: a2 → (a3, d3). It is the forward (decomposition) counterpart of the L3 reconstruction stage.
- Consumes 4 level-2 approximation samples per valid beat. Applies 8-tap low-pass and high-pass analysis filters with decimation by 2.
- Emits 2 approximation (a3) and 2 detail (d3) coefficients per beat.
- Sits between decomposition L2 and the level-3 threshold/reconstruction path. Fully pipelined; accepts a beat every cycle.

Parameters:
INTERNAL_WIDTH, 48, sample/coefficient data width (signed, same fixed-point as a2).
COEF_WIDTH, 25, filter coefficient width (signed).
COEF_FRAC, 23, fractional bits of the filter coefficients.
DEC_L0..DEC_L7, 0, signed [COEF_WIDTH-1:0] low-pass analysis taps.
DEC_H0..DEC_H7, 0, signed [COEF_WIDTH-1:0] high-pass analysis taps.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
clr  in  1  synchronous soft clear: flushes history, warm-up and valid pipe.
din_valid  in  1  beat qualifier for a2_0..a2_3.
a2_0..a2_3  in  INTERNAL_WIDTH each  consecutive input samples x[4j..4j+3]; a2_0 is oldest.
dout_valid  out  1  qualifies a3_*/d3_*.
a3_0, a3_1  out  INTERNAL_WIDTH each  approximation a3[2j], a3[2j+1].
d3_0, d3_1  out  INTERNAL_WIDTH each  detail d3[2j], d3[2j+1].

Behaviour:
- Filter equations. For p in {0,1}:
  - a3[2j+p] = Σ_{n=0..7} DEC_Ln · x[4j+2p+1−n]
  - d3[2j+p] = Σ_{n=0..7} DEC_Hn · x[4j+2p+1−n]
- History:
  - 6 registers hold x[4j−6..4j−1].
  - Updated only on accepted beats (din_valid=1): shift in a2_0..a2_3 and drop the oldest 4.
  - Hold when din_valid=0.
- Warm-up:
  - 2-bit saturating counter of accepted beats.
  - A beat is "productive" only if the counter is 2 when it arrives, i.e. the first two beats after rst/clr produce no output.
  - The counter increments on each accepted beat and saturates at 2.
- Pipeline, 3 stages. Latency is 3 cycles from an accepted productive beat to dout_valid:
  - S1: 32 products, each full width INTERNAL_WIDTH+COEF_WIDTH. Registered when valid_s0 is set.
  - S2: four 8-term sums, width INTERNAL_WIDTH+COEF_WIDTH+3. Registered when valid_s1 is set.
  - S3: output registers.
- Each stage's data registers load only when that stage's valid bit is set; otherwise they hold. valid_s1/valid_s2/dout_valid form a plain shift pipe.
- Truncation: output = sum[COEF_FRAC+INTERNAL_WIDTH−1 : COEF_FRAC].
  - Arithmetic floor (truncation toward −∞), no rounding.
  - Wraps on overflow, no saturation.
- Bubbles: gaps in din_valid are allowed at any spacing. Output order and values depend only on the sequence of accepted beats, never on gap timing.
- rst (highest priority): dout_valid=0, all four data outputs=0, history=0, warm-up=0, all stage valids=0.
- clr without rst:
  - Same as rst for history, warm-up and all valid bits. Data output registers hold their values.
  - din_valid in the same cycle as clr is discarded: not stored, not counted.
  - In-flight results are dropped. dout_valid=0 from the next cycle.
- Reset or clr mid-stream: the next accepted beat is beat 0 again. History is zeros; the two warm-up beats are required again.
- No backpressure. Downstream must accept every dout_valid cycle.

Test Plan:
- Impulse, low-pass.
  - Setup: DEC_Ln=(n+1)<<20; beats at consecutive cycles: beat0=0,0,0,0; beat1=0,0,0,0; beat2 a2_0=800, others 0; beat3=0,0,0,0.
  - Required: no dout_valid for beats 0/1. Three cycles after beat2: a3_0=200, a3_1=400. Next cycle: a3_0=600, a3_1=800.
- Impulse, high-pass.
  - Setup: same stimulus with DEC_Hn=−((n+1)<<20).
  - Required: d3 = −200, −400, then −600, −800, in the same cycles as the low-pass results.
- Bubbles.
  - Setup: repeat the impulse test with 2 idle cycles between every beat.
  - Required: identical output values. Each dout_valid lands exactly 3 cycles after its beat. Outputs hold between pulses.
- Truncation.
  - Setup: DEC_L0=1<<22 (0.5), other taps 0; input x=−3 at position 4j+1.
  - Required: a3_0 = −2 (floor of −1.5).
  - Setup: input x=3 at the same position.
  - Required: a3_0 = 1.
- Reset/clear mid-stream.
  - Setup: stream 5 beats, assert clr together with din_valid on beat 5, then send 3 more beats.
  - Required: dout_valid low from the cycle after clr. Beat 5 is ignored. The first output after clr arrives 3 cycles after the 3rd post-clr beat, computed with zero history.
  - Setup: assert rst at the same point instead.
  - Required: all outputs read 0 as well.
- DC response.
  - Setup: constant input 1000; DEC_Ln set to sym4 low-pass taps scaled by 2^23.
  - Required: after warm-up, a3 is within ±1 LSB of round(1000·ΣDEC_L/2^23). d3 is within ±1 LSB of 0.
